// File: rtl/led_pkg.sv
// Shared LED constants and helpers, used by the fade driver and the PIO top-level wiring.
package led_pkg;

    localparam int unsigned LED_WIDTH            = 8;
    localparam int unsigned LED_PWM_BITS         = 8;
    localparam int unsigned LED_PRESCALE_DEFAULT = 50000;

    typedef enum logic [1:0] {
        LvlHold,
        LvlInc,
        LvlDec,
        LvlForce
    } lvl_op_e;

    // Counter width for a modulus; a modulus of 1 still needs one storage bit.
    function automatic int unsigned cnt_width(input int unsigned modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: saturating brightness level that ramps toward the target, plus a
// registered PWM comparator against the shared PWM counter.
module led_fade_channel
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS = LED_PWM_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                target,
    input  logic                step_tick,
    input  logic                bypass,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                pwm_out,
    output logic                at_target
);

    localparam logic [PWM_BITS-1:0] LevelMax = '1;

    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] extreme;
    logic                pwm_q, pwm_d;
    lvl_op_e             op;

    assign extreme = target ? LevelMax : '0;

    // Bypass outranks a step tick in the same cycle.
    always_comb begin
        op = LvlHold;
        if (bypass) begin
            op = LvlForce;
        end else if (step_tick && target && (level_q != LevelMax)) begin
            op = LvlInc;
        end else if (step_tick && !target && (level_q != '0)) begin
            op = LvlDec;
        end
    end

    always_comb begin
        level_d = level_q;
        unique case (op)
            LvlForce: level_d = extreme;
            LvlInc:   level_d = level_q + 1'b1;
            LvlDec:   level_d = level_q - 1'b1;
            default:  level_d = level_q;
        endcase
    end

    // Full level is pinned high so there is no dark cycle when pwm_cnt hits MAX.
    always_comb begin
        pwm_d = 1'b0;
        if (bypass) begin
            pwm_d = target;
        end else if (level_q == '0) begin
            pwm_d = 1'b0;
        end else if (level_q == LevelMax) begin
            pwm_d = 1'b1;
        end else begin
            pwm_d = (level_q > pwm_cnt);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= '0;
            pwm_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_out   = pwm_q;
    assign at_target = (level_q == extreme);

endmodule

// File: rtl/led_fade_driver.sv
// LED fade driver: registers the PIO pattern, runs the fade-step prescaler and the PWM
// counter, and fans them out to one fading channel per LED.
module led_fade_driver
    import led_pkg::*;
#(
    parameter int unsigned WIDTH    = LED_WIDTH,
    parameter int unsigned PWM_BITS = LED_PWM_BITS,
    parameter int unsigned PRESCALE = LED_PRESCALE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] led_in,
    input  logic             bypass,
    output logic [WIDTH-1:0] led_out,
    output logic             busy
);

    localparam int unsigned          PsWidth = cnt_width(PRESCALE);
    localparam logic [PsWidth-1:0]   PsLast  = PsWidth'(PRESCALE - 1);

    logic [PsWidth-1:0]  prescale_q, prescale_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [WIDTH-1:0]    target_q;
    logic                busy_q, busy_d;
    logic                step_tick;
    logic [WIDTH-1:0]    chan_pwm;
    logic [WIDTH-1:0]    chan_at_target;

    assign step_tick = (prescale_q == PsLast);

    always_comb begin
        prescale_d = step_tick ? '0 : prescale_q + 1'b1;
        pwm_cnt_d  = pwm_cnt_q + 1'b1;
        busy_d     = |(~chan_at_target);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_q <= '0;
            pwm_cnt_q  <= '0;
            target_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            pwm_cnt_q  <= pwm_cnt_d;
            target_q   <= led_in;
            busy_q     <= busy_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        led_fade_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .target    (target_q[i]),
            .step_tick (step_tick),
            .bypass    (bypass),
            .pwm_cnt   (pwm_cnt_q),
            .pwm_out   (chan_pwm[i]),
            .at_target (chan_at_target[i])
        );
    end

    assign led_out = chan_pwm;
    assign busy    = busy_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver with PWM_BITS=4 (MAX=15) and PRESCALE=2.
module tb_led_fade_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] led_in = 8'h00;
    logic       bypass = 1'b0;
    logic [7:0] led_out;
    logic       busy;

    int checks = 0;
    int errors = 0;

    led_fade_driver #(
        .WIDTH    (8),
        .PWM_BITS (4),
        .PRESCALE (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .led_in  (led_in),
        .bypass  (bypass),
        .led_out (led_out),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Edge k after reset release: prescaler=k%2, pwm_cnt=k%16, levels step on even k.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] pattern, input logic byp);
        reset  = 1'b1;
        led_in = pattern;
        bypass = byp;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(8'hFF, 1'b0);
        repeat (18) step();
        checks++;
        if (led_out !== 8'hFF) begin
            errors++;
            $display("FAIL reset_pre_ramp: led_out=%h expected ff", led_out);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_busy: busy=%b expected 1", busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (led_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_async_led: led_out=%h expected 00", led_out);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_busy: busy=%b expected 0", busy);
        end
        step();
        reset = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k <= 16) begin
                checks++;
                if (led_out !== 8'h00) begin
                    errors++;
                    $display("FAIL reset_restart_k%0d: led_out=%h expected 00", k, led_out);
                end
            end else begin
                checks++;
                if (led_out !== 8'hFF) begin
                    errors++;
                    $display("FAIL reset_restart_k%0d: led_out=%h expected ff", k, led_out);
                end
            end
            if (k == 2) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_restart_busy: busy=%b expected 1", busy);
                end
            end
        end
    endtask

    task automatic test_ramp();
        do_reset(8'h01, 1'b0);
        for (int k = 1; k <= 46; k++) begin
            step();
            if (k == 2 || k == 30) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL ramp_busy_k%0d: busy=%b expected 1", k, busy);
                end
            end
            if (k == 31) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL ramp_busy_done: busy=%b expected 0", busy);
                end
            end
            if (k >= 31) begin
                checks++;
                if (led_out !== 8'h01) begin
                    errors++;
                    $display("FAIL ramp_full_k%0d: led_out=%h expected 01", k, led_out);
                end
            end
        end
    endtask

    task automatic test_reversal();
        logic exp_bit;
        do_reset(8'h01, 1'b0);
        for (int k = 1; k <= 44; k++) begin
            step();
            if (k >= 17 && k <= 22) begin
                exp_bit = (k <= 20);
                checks++;
                if (led_out[0] !== exp_bit) begin
                    errors++;
                    $display("FAIL reversal_duty_k%0d: led_out[0]=%b expected %b",
                             k, led_out[0], exp_bit);
                end
            end
            if (k == 28) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL reversal_busy_k28: busy=%b expected 1", busy);
                end
            end
            if (k == 29) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL reversal_busy_k29: busy=%b expected 0", busy);
                end
            end
            if (k >= 29) begin
                checks++;
                if (led_out !== 8'h00) begin
                    errors++;
                    $display("FAIL reversal_off_k%0d: led_out=%h expected 00", k, led_out);
                end
            end
            if (k == 14) led_in = 8'h00;
        end
    endtask

    // Target toggles every tick from level 4, so the level alternates 4,5 and never
    // exceeds pwm_cnt once pwm_cnt reaches 4.
    task automatic test_duty();
        int high;
        high = 0;
        do_reset(8'h01, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k >= 17 && led_out[0] === 1'b1) high++;
            if (k >= 9 && (k % 2) == 1) led_in[0] = ~led_in[0];
        end
        checks++;
        if (high !== 4) begin
            errors++;
            $display("FAIL duty_level4: high_cycles=%0d expected 4", high);
        end
        checks++;
        if (led_out[7:1] !== 7'h00) begin
            errors++;
            $display("FAIL duty_other_bits: led_out[7:1]=%h expected 00", led_out[7:1]);
        end
    endtask

    task automatic test_bypass();
        do_reset(8'h00, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 3) begin
                checks++;
                if (led_out !== 8'h00) begin
                    errors++;
                    $display("FAIL bypass_latency: led_out=%h expected 00", led_out);
                end
            end
            if (k >= 4 && k <= 12) begin
                checks++;
                if (led_out !== 8'hA5) begin
                    errors++;
                    $display("FAIL bypass_out_k%0d: led_out=%h expected a5", k, led_out);
                end
            end
            if (k == 4 || k == 8) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL bypass_busy_k%0d: busy=%b expected 1", k, busy);
                end
            end
            if (k == 5 || k == 6) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL bypass_busy_k%0d: busy=%b expected 0", k, busy);
                end
            end
            if (k == 13) begin
                checks++;
                if (led_out !== 8'h00) begin
                    errors++;
                    $display("FAIL bypass_fade_k13: led_out=%h expected 00", led_out);
                end
            end
            if (k == 2) begin
                bypass = 1'b1;
                led_in = 8'hA5;
            end
            if (k == 6) begin
                bypass = 1'b0;
                led_in = 8'h00;
            end
        end
    endtask

    // Both channels at level 3 when bypass lands on a tick cycle: bit0 (target 1) must
    // go to 15 and bit1 (target 0) to 0, with no +/-1 step.
    task automatic test_simultaneous();
        do_reset(8'h03, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            step();
            if (k >= 8) begin
                checks++;
                if (led_out !== 8'h01) begin
                    errors++;
                    $display("FAIL simul_out_k%0d: led_out=%h expected 01", k, led_out);
                end
            end
            if (k == 9 || k == 24) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL simul_busy_k%0d: busy=%b expected 0", k, busy);
                end
            end
            if (k == 6) led_in = 8'h01;
            if (k == 7) bypass = 1'b1;
            if (k == 8) bypass = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_reversal();
        test_duty();
        test_bypass();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
